// File: rtl/adc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_fetch_pkg
//  Description : Shared constants and FSM state type for the ADC block fetch
//                path (capture SRAM -> MDIO register file sample buffer).
//  Revision    : 1.0  initial release
// ============================================================================
package adc_fetch_pkg;

    localparam int SMP_W        = 9;
    localparam int SMP_PER_WORD = 8;
    localparam int NUM_SMP      = 96;
    localparam int BEATS        = NUM_SMP / SMP_PER_WORD;
    localparam int MEM_DW       = SMP_W * SMP_PER_WORD;
    localparam int AW           = 19;

    // Block index whose commit marks the end of the whole readout
    localparam logic [14:0] LAST_BLK = 15'h7fff;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } fetch_state_e;

endpackage : adc_fetch_pkg
`default_nettype wire

// File: rtl/adc_fetch_unpack.sv
`default_nettype none
// ============================================================================
//  Module      : adc_fetch_unpack
//  Description : Splits one SRAM word into its samples (sample k occupies
//                bits [SMP_W*k +: SMP_W]) and decodes the current beat into a
//                one-hot write enable for the sample buffer.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_fetch_unpack #(
    parameter int SMP_W        = adc_fetch_pkg::SMP_W,
    parameter int SMP_PER_WORD = adc_fetch_pkg::SMP_PER_WORD,
    parameter int BEATS        = adc_fetch_pkg::BEATS,
    parameter int BEAT_W       = 4
) (
    input  logic [SMP_W*SMP_PER_WORD-1:0] rdata,
    input  logic [BEAT_W-1:0]             beat,
    input  logic                          wr,
    output logic [SMP_W-1:0]              smp [0:SMP_PER_WORD-1],
    output logic [BEATS-1:0]              beat_we
);

    import adc_fetch_pkg::*;

    // Fixed bit-slice per sample lane
    generate
        for (genvar k = 0; k < SMP_PER_WORD; k++) begin : g_split
            assign smp[k] = rdata[k*SMP_W +: SMP_W];
        end
    endgenerate

    // One-hot beat decode, qualified by the capture strobe
    always_comb begin
        beat_we = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (wr && (beat == BEAT_W'(b))) begin
                beat_we[b] = 1'b1;
            end
        end
    end

endmodule : adc_fetch_unpack
`default_nettype wire

// File: rtl/adc_mdio_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : adc_mdio_fetch
//  Description : Fetches one block of samples (BEATS SRAM words) from the
//                capture SRAM and presents it to the MDIO register file.
//                Triggered by read_pls (block 0) or mdio_read (mdio_raddr).
//                Optional macro ADC_FETCH_DBUF_EN: captured beats go to a
//                shadow buffer and mdio_dout is loaded all at once when the
//                final beat lands, so a partially fetched block is never
//                visible. Without it each beat writes mdio_dout directly.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_mdio_fetch #(
    parameter int SMP_W        = adc_fetch_pkg::SMP_W,
    parameter int SMP_PER_WORD = adc_fetch_pkg::SMP_PER_WORD,
    parameter int NUM_SMP      = adc_fetch_pkg::NUM_SMP,
    parameter int AW           = adc_fetch_pkg::AW
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          read_pls,
    input  logic                          mdio_read,
    input  logic [14:0]                   mdio_raddr,
    input  logic [3:0]                    cfg_mdio_rd_cnt,
    output logic                          mem_ce,
    output logic [AW-1:0]                 mem_addr,
    input  logic [SMP_W*SMP_PER_WORD-1:0] mem_rdata,
    output logic [SMP_W-1:0]              mdio_dout [0:NUM_SMP-1],
    output logic                          mdio_data_vld,
    output logic                          mdio_read_done,
    output logic                          fetch_busy,
    output logic                          fetch_ovf
);

    import adc_fetch_pkg::*;

    localparam int              BEATS     = NUM_SMP / SMP_PER_WORD;
    localparam int              BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    fetch_state_e        state;
    fetch_state_e        state_nxt;
    logic                trig;
    logic [14:0]         trig_blk;
    logic                accept;
    logic                capture;
    logic [14:0]         blk;
    logic [AW-1:0]       base;
    logic [BEAT_W-1:0]   beat;
    logic [3:0]          lat;
    logic [3:0]          lat_cnt;
    logic [SMP_W-1:0]    smp [0:SMP_PER_WORD-1];
    logic [BEATS-1:0]    beat_we;

    // read_pls has priority and always targets block 0
    assign trig     = read_pls | mdio_read;
    assign trig_blk = read_pls ? 15'd0 : mdio_raddr;

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and SRAM / status outputs
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        capture       = 1'b0;
        mem_ce        = 1'b0;
        mem_addr      = '0;
        mdio_data_vld = 1'b0;
        fetch_busy    = 1'b1;
        case (state)
            IDLE: begin
                fetch_busy = 1'b0;
                if (trig) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_ce    = 1'b1;
                mem_addr  = base + AW'(beat);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (lat_cnt == lat) begin
                    capture   = 1'b1;
                    state_nxt = (beat == LAST_BEAT) ? COMMIT : REQ;
                end
            end
            COMMIT: begin
                mdio_data_vld = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Fetch context: block, base address, beat index and latency counter.
    // Latency is frozen at trigger time so cfg changes only affect later fetches.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk     <= '0;
            base    <= '0;
            beat    <= '0;
            lat     <= 4'd1;
            lat_cnt <= '0;
        end else begin
            if (accept) begin
                blk  <= trig_blk;
                base <= AW'(trig_blk) * AW'(BEATS);
                beat <= '0;
                lat  <= (cfg_mdio_rd_cnt == 4'd0) ? 4'd1 : cfg_mdio_rd_cnt;
            end
            if (state == REQ) begin
                lat_cnt <= 4'd1;
            end else if ((state == WAIT) && !capture) begin
                lat_cnt <= lat_cnt + 4'd1;
            end
            if (capture && (beat != LAST_BEAT)) begin
                beat <= beat + BEAT_W'(1);
            end
        end
    end

    // Sticky flags: overflow on any trigger while busy; an accepted read_pls
    // starts a fresh readout and clears both flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_ovf      <= 1'b0;
            mdio_read_done <= 1'b0;
        end else begin
            if (fetch_busy && trig) begin
                fetch_ovf <= 1'b1;
            end else if (accept && read_pls) begin
                fetch_ovf <= 1'b0;
            end
            if (accept && read_pls) begin
                mdio_read_done <= 1'b0;
            end else if ((state == COMMIT) && (blk == LAST_BLK)) begin
                mdio_read_done <= 1'b1;
            end
        end
    end

    adc_fetch_unpack #(
        .SMP_W        (SMP_W),
        .SMP_PER_WORD (SMP_PER_WORD),
        .BEATS        (BEATS),
        .BEAT_W       (BEAT_W)
    ) u_unpack (
        .rdata   (mem_rdata),
        .beat    (beat),
        .wr      (capture),
        .smp     (smp),
        .beat_we (beat_we)
    );

`ifdef ADC_FETCH_DBUF_EN
    logic [SMP_W-1:0] shadow [0:NUM_SMP-1];

    // Shadow capture of all but the final beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SMP; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int b = 0; b < BEATS - 1; b++) begin
                if (beat_we[b]) begin
                    for (int k = 0; k < SMP_PER_WORD; k++) begin
                        shadow[b*SMP_PER_WORD + k] <= smp[k];
                    end
                end
            end
        end
    end

    // Whole-block load of the output buffer as the final beat arrives
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SMP; i++) begin
                mdio_dout[i] <= '0;
            end
        end else if (beat_we[BEATS-1]) begin
            for (int b = 0; b < BEATS; b++) begin
                for (int k = 0; k < SMP_PER_WORD; k++) begin
                    if (b == BEATS - 1) begin
                        mdio_dout[b*SMP_PER_WORD + k] <= smp[k];
                    end else begin
                        mdio_dout[b*SMP_PER_WORD + k] <= shadow[b*SMP_PER_WORD + k];
                    end
                end
            end
        end
    end
`else
    // Each captured beat lands straight in the output buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_SMP; i++) begin
                mdio_dout[i] <= '0;
            end
        end else begin
            for (int b = 0; b < BEATS; b++) begin
                if (beat_we[b]) begin
                    for (int k = 0; k < SMP_PER_WORD; k++) begin
                        mdio_dout[b*SMP_PER_WORD + k] <= smp[k];
                    end
                end
            end
        end
    end
`endif

endmodule : adc_mdio_fetch
`default_nettype wire

// File: doc/adc_mdio_fetch.md
# adc_mdio_fetch

Fetches the 96-sample ADC block from capture SRAM and feeds it to the MDIO register file. It takes the block-advance request (`mdio_read`, `mdio_raddr`) and the memory read latency (`cfg_mdio_rd_cnt`) from the register file, and returns `mdio_dout[0:95]`, `mdio_data_vld` and `mdio_read_done`. The block sits between the capture SRAM read port and the register file. Each fetch is 12 SRAM reads of 72 bits, unpacked into 9-bit samples.

## Interface
Parameters:
- `SMP_W`, 9: sample width.
- `SMP_PER_WORD`, 8: samples per SRAM word.
- `NUM_SMP`, 96: samples per block.
- `AW`, 19: SRAM address width.

Derived constants:
- `BEATS = NUM_SMP/SMP_PER_WORD = 12`.
- `MEM_DW = SMP_W*SMP_PER_WORD = 72`.

Ports:
- `clk`  in  1: clock.
- `rstn`  in  1: reset, asynchronous, active-low.
- `read_pls`  in  1: one-cycle pulse; prefetch block 0 and clear done/overflow.
- `mdio_read`  in  1: one-cycle pulse; fetch the block at `mdio_raddr`.
- `mdio_raddr`  in  15: block index, sampled when `mdio_read`=1.
- `cfg_mdio_rd_cnt`  in  4: SRAM read latency in cycles; 0 is treated as 1.
- `mem_ce`  out  1: SRAM read strobe.
- `mem_addr`  out  AW: SRAM word address.
- `mem_rdata`  in  MEM_DW: SRAM read data.
- `mdio_dout`  out  SMP_W x [0:NUM_SMP-1]: sample buffer.
- `mdio_data_vld`  out  1: one-cycle pulse when a block is committed.
- `mdio_read_done`  out  1: level; the final block (index 15'h7fff) has been committed.
- `fetch_busy`  out  1: fetch in progress.
- `fetch_ovf`  out  1: sticky; a trigger arrived while busy.

## Operation
- Triggers:
  - `read_pls`: block index 0.
  - `mdio_read`: block index = `mdio_raddr`.
  - Both in the same cycle: `read_pls` wins.
- Trigger while `fetch_busy`: ignored, `fetch_ovf` set to 1.
- Sticky clears:
  - `read_pls` clears `fetch_ovf` and `mdio_read_done`, but only when accepted.
  - A `read_pls` ignored while busy sets `fetch_ovf` instead.
- Base address = block*12, computed with width AW and no overflow (max 393204+11 < 2^19).
- FSM states:
  - IDLE: on an accepted trigger, latch the base, beat=0, latency L = max(`cfg_mdio_rd_cnt`,1) → REQ.
  - REQ: `mem_ce`=1, `mem_addr`=base+beat for exactly one cycle; wait counter=1 → WAIT.
  - WAIT: increment the counter; when counter==L, capture `mem_rdata` → CAPT decision in the same cycle.
  - CAPT decision: if beat<11, beat+1 → REQ. Else → COMMIT.
  - COMMIT: one cycle. Pulse `mdio_data_vld`. If the latched block==15'h7fff, set `mdio_read_done`. → IDLE.
- Unpacking: `mem_rdata[9k+8:9k]` → sample beat*8+k, for k=0..7.
- L is latched at trigger time. `cfg_mdio_rd_cnt` changes during a fetch take effect on the next fetch.
- `fetch_busy` = (state != IDLE).

## Timing
- Reset values:
  - `mem_ce`=0, `mem_addr`=0.
  - `mdio_dout` all zero.
  - `mdio_data_vld`=0, `mdio_read_done`=0, `fetch_busy`=0, `fetch_ovf`=0.
  - FSM = IDLE.
- Cycle numbering, with the trigger sampled at the edge ending cycle 0:
  - REQ of beat b in cycle 1+b(L+1).
  - Capture of beat b at the edge ending cycle 1+b(L+1)+L.
  - COMMIT / `mdio_data_vld` high in cycle 12(L+1)+1; with L=1 that is cycle 25.
- Next trigger is accepted in the COMMIT cycle + 1.
- Reset mid-fetch: everything returns to reset values immediately and the partial data is discarded.

## Configuration
- `ADC_FETCH_DBUF_EN` defined:
  - Captured beats go into a shadow buffer.
  - `mdio_dout` is updated atomically at the COMMIT edge, so the register file never sees a mixed block.
- `ADC_FETCH_DBUF_EN` undefined:
  - Each beat writes `mdio_dout` directly at its capture edge.
  - No shadow storage.
  - `mdio_data_vld` timing is unchanged.

## Structure
- Package `adc_fetch_pkg`:
  - Constants `SMP_W`, `SMP_PER_WORD`, `NUM_SMP`, `BEATS`, `MEM_DW`, `AW`.
  - Last-block constant 15'h7fff.
  - FSM state enum: IDLE, REQ, WAIT, COMMIT.
- One sub-module, `adc_fetch_unpack`: the combinational 72-bit → 8x9 split plus beat-indexed write enable into the buffer, instantiated once.

## Test plan
- L=1, `mem_rdata` = beat-dependent pattern, `mdio_read` with `mdio_raddr`=5:
  - `mem_addr` steps 60..71.
  - `mdio_data_vld` pulses in cycle 25.
  - `mdio_dout[8b+k]` matches the pattern.
- `cfg_mdio_rd_cnt`=0 vs 4:
  - Commit in cycle 25 vs 61.
  - Changing cfg mid-fetch does not alter the current fetch's latency.
- `mdio_read` during busy → `fetch_ovf`=1, no restart. A later accepted `read_pls` → `fetch_ovf`=0, `mem_addr` starts at 0.
- `mdio_raddr`=15'h7fff: `mem_addr` 393204..393215, `mdio_read_done`=1 after commit. Next accepted `read_pls` clears it.
- `read_pls` and `mdio_read` (raddr 3) in the same cycle → fetch starts at address 0.
- `rstn` low during beat 6, then a new fetch:
  - All outputs zero during reset.
  - With `ADC_FETCH_DBUF_EN`, `mdio_dout` changes only at commit. Without it, `mdio_dout` changes per beat.
